// File: rtl/writeback_scoreboard_if.sv
// Pipeline-side bundle for the writeback scoreboard: MEM/WB results, decode
// issue/source info, and the register file write port back out.
interface writeback_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_valid;
    logic              wb_reg_wr;
    logic              wb_mem_to_reg;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_alu_result;
    logic [DATA_W-1:0] wb_mem_data;
    logic              issue_valid;
    logic              issue_reg_wr;
    logic [ADDR_W-1:0] issue_dest;
    logic [ADDR_W-1:0] inst_read_reg_addr1;
    logic [ADDR_W-1:0] inst_read_reg_addr2;
    logic              stall_flag;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              wb_underflow;

    modport master (
        output wb_valid, wb_reg_wr, wb_mem_to_reg, wb_dest, wb_alu_result, wb_mem_data,
        output issue_valid, issue_reg_wr, issue_dest, inst_read_reg_addr1, inst_read_reg_addr2,
        input  stall_flag, reg_wr, reg_wr_addr, reg_wr_data, wb_underflow
    );

    modport slave (
        input  wb_valid, wb_reg_wr, wb_mem_to_reg, wb_dest, wb_alu_result, wb_mem_data,
        input  issue_valid, issue_reg_wr, issue_dest, inst_read_reg_addr1, inst_read_reg_addr2,
        output stall_flag, reg_wr, reg_wr_addr, reg_wr_data, wb_underflow
    );
endinterface

// File: rtl/writeback_scoreboard.sv
// Drives the register file write port from MEM/WB and tracks in-flight writes
// per register so decode stalls on RAW hazards or a saturated pending counter.
module writeback_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input logic              clk,
    input logic              reset,
    writeback_scoreboard_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [CNT_W-1:0] pend [NUM_REGS];
    logic             wb_acc;
    logic             issue_inc;
    logic             raw_hit;
    logic             sat_hit;
    logic             stall;

    assign wb_acc = bus.wb_valid && bus.wb_reg_wr && (bus.wb_dest != '0);

    always_comb begin
        raw_hit = ((bus.inst_read_reg_addr1 != '0) && (pend[bus.inst_read_reg_addr1] != '0)) ||
                  ((bus.inst_read_reg_addr2 != '0) && (pend[bus.inst_read_reg_addr2] != '0));
        sat_hit = bus.issue_reg_wr && (bus.issue_dest != '0) && (pend[bus.issue_dest] == '1);
        stall   = bus.issue_valid && (raw_hit || sat_hit);
    end

    assign bus.stall_flag = stall;
    assign issue_inc      = bus.issue_valid && bus.issue_reg_wr && (bus.issue_dest != '0) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.reg_wr       <= 1'b0;
            bus.reg_wr_addr  <= '0;
            bus.reg_wr_data  <= '0;
            bus.wb_underflow <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
        end else begin
            bus.reg_wr      <= wb_acc;
            bus.reg_wr_addr <= bus.wb_dest;
            bus.reg_wr_data <= bus.wb_mem_to_reg ? bus.wb_mem_data : bus.wb_alu_result;
            // Drain happens on the cycle the write is presented, so the mark
            // outlives the register file commit.
            if (bus.reg_wr && (pend[bus.reg_wr_addr] == '0)) bus.wb_underflow <= 1'b1;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (issue_inc && (bus.issue_dest == ADDR_W'(r)) &&
                    !(bus.reg_wr && (bus.reg_wr_addr == ADDR_W'(r)))) begin
                    pend[r] <= pend[r] + CNT_W'(1);
                end else if (bus.reg_wr && (bus.reg_wr_addr == ADDR_W'(r)) &&
                             !(issue_inc && (bus.issue_dest == ADDR_W'(r)))) begin
                    if (pend[r] != '0) pend[r] <= pend[r] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/writeback_scoreboard.md
Name: writeback_scoreboard

Overview:
- Write-side partner of the decode-stage register file.
- Accepts completed results from the MEM/WB stage, selects between the ALU result and the load data, and drives the register file write port (reg_wr, reg_wr_addr, reg_wr_data) one cycle later.
- Keeps a per-register pending-write scoreboard that is filled by decode issue and drained by writeback.
- From the scoreboard it generates stall_flag for decode, so the register file is never read while a write to that register is still in flight.

Parameters:
- DATA_W, 32, data width of results and reg_wr_data.
- NUM_REGS, 32, number of architectural registers; address width is log2(NUM_REGS) = 5.
- CNT_W, 2, width of each pending-write counter; saturation value is 2^CNT_W-1 = 3.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- wb_valid  in  1  MEM/WB holds a completed instruction this cycle.
- wb_reg_wr  in  1  completed instruction writes a register.
- wb_mem_to_reg  in  1  1 selects wb_mem_data, 0 selects wb_alu_result.
- wb_dest  in  5  destination register of the completed instruction.
- wb_alu_result  in  DATA_W  ALU result.
- wb_mem_data  in  DATA_W  load data.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_reg_wr  in  1  the issuing instruction will write a register.
- issue_dest  in  5  destination register of the issuing instruction.
- inst_read_reg_addr1  in  5  source register 1 of the issuing instruction.
- inst_read_reg_addr2  in  5  source register 2 of the issuing instruction.
- stall_flag  out  1  combinational; holds decode and the register file read.
- reg_wr  out  1  registered write enable to the register file.
- reg_wr_addr  out  5  registered write address.
- reg_wr_data  out  DATA_W  registered write data.
- wb_underflow  out  1  sticky error: writeback arrived for a register with no pending write.

Behaviour:
- Reset (posedge with reset=1):
  - reg_wr=0, reg_wr_addr=0, reg_wr_data=0, wb_underflow=0.
  - All pending counters cleared to 0.
  - Reset wins over every simultaneous event; in-flight writes are discarded, not completed.
- Write accept: wb_acc = wb_valid & wb_reg_wr & (wb_dest != 0).
- Write port:
  - On each posedge: reg_wr <= wb_acc; reg_wr_addr <= wb_dest; reg_wr_data <= wb_mem_to_reg ? wb_mem_data : wb_alu_result.
  - Latency is 1 cycle from wb_acc to the write appearing on the port.
  - reg_wr is high for exactly one cycle per accepted result.
  - Back-to-back accepts produce back-to-back writes with no bubble.
  - When reg_wr=0, addr and data still update but are don't-care.
- Register 0:
  - Never written: a wb_dest of 0 produces reg_wr=0.
  - Never marked pending and never causes a stall.
- Scoreboard:
  - One CNT_W-bit counter per register, pend[r].
  - Increment condition: issue_valid & issue_reg_wr & issue_dest != 0 & !stall_flag increments pend[issue_dest].
  - Decrement condition: reg_wr=1 (the cycle the write is presented) decrements pend[reg_wr_addr] at the end of that cycle.
  - The pending mark therefore clears one cycle after wb_acc, after the register file has committed the write.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - Decrement while pend=0: counter stays 0 (no wrap) and wb_underflow is set; it clears only on reset.
- stall_flag (combinational) = issue_valid & (RAW | SAT).
  - RAW = (addr1 != 0 & pend[addr1] != 0) | (addr2 != 0 & pend[addr2] != 0).
  - SAT = issue_reg_wr & issue_dest != 0 & pend[issue_dest] == 3.
  - While stalled, issue does not increment the scoreboard.
  - stall_flag drops in the same cycle the blocking counter reaches 0.
- Source register equal to issue_dest with no pending write: no stall.
- Sources and destinations are checked independently.

Test Plan:
- Reset: reset=1 for 2 cycles with wb_valid=1 → reg_wr=0, addr=0, data=0, wb_underflow=0, stall_flag=0 afterwards.
- Write path, ALU result: wb_valid=1, wb_reg_wr=1, wb_dest=5, wb_mem_to_reg=0, alu=0x1234 → next cycle reg_wr=1, addr=5, data=0x1234, high for one cycle.
- Write path, load data: same as above with wb_mem_to_reg=1, mem=0xDEADBEEF → next cycle reg_wr=1, addr=5, data=0xDEADBEEF.
- RAW stall: issue dest=7, then issue src1=7 → stall_flag=1; wb_dest=7 accepted at cycle N → reg_wr=1 at N+1, stall_flag=0 from N+2.
- Register 0 and saturation: wb_dest=0 → reg_wr stays 0. Issue dest=9 three times with no writeback → a fourth issue to dest 9 stalls; one writeback to 9 releases it.
- Simultaneous events and underflow:
  - Issue dest=4 in the same cycle reg_wr presents addr=4 with pend[4]=1 → pend[4] stays 1.
  - Writeback to register 12 with pend[12]=0 → wb_underflow=1, held until reset.
